// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: computes the 64-bit result at issue and releases
// it into HI/LO after a fixed latency, stalling the pipeline while a result is pending.
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] dInA,
    input  logic [31:0] dInB,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;

    logic               is_muldiv;
    logic               is_mul;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        div_b;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [63:0]        result;

    assign is_mul    = (MDUOp == OP_MULT) | (MDUOp == OP_MULTU);
    assign is_muldiv = is_mul | (MDUOp == OP_DIV) | (MDUOp == OP_DIVU);
    assign stall     = busy | (start & is_muldiv);

    // The divider never sees a zero divisor or the one signed overflow pair;
    // those results are substituted below and the real quotient is discarded.
    assign div_zero = (dInB == 32'd0);
    assign div_ovf  = (dInA == 32'h8000_0000) & (dInB == 32'hFFFF_FFFF);
    assign div_b    = (div_zero | div_ovf) ? 32'd1 : dInB;

    assign prod_s = $signed({{32{dInA[31]}}, dInA}) * $signed({{32{dInB[31]}}, dInB});
    assign prod_u = {32'd0, dInA} * {32'd0, dInB};
    assign quot_s = $signed(dInA) / $signed(div_b);
    assign rem_s  = $signed(dInA) % $signed(div_b);
    assign quot_u = dInA / div_b;
    assign rem_u  = dInA % div_b;

    always_comb begin
        result = 64'd0;
        case (MDUOp)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (div_zero)
                    result = {dInA, 32'hFFFF_FFFF};
                else if (div_ovf)
                    result = {32'd0, 32'h8000_0000};
                else
                    result = {rem_s, quot_s};
            end
            OP_DIVU: begin
                if (div_zero)
                    result = {dInA, 32'hFFFF_FFFF};
                else
                    result = {rem_u, quot_u};
            end
            default: result = 64'd0;
        endcase
    end

    // Flush overrides everything, including a same-cycle start or the completion write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            count   <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (flush) begin
            state   <= IDLE;
            busy    <= 1'b0;
            count   <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_muldiv) begin
                            {pend_hi, pend_lo} <= result;
                            count <= is_mul ? MUL_CNT : DIV_CNT;
                            state <= RUN;
                            busy  <= 1'b1;
                        end else if (MDUOp == OP_MTHI) begin
                            hi <= dInA;
                        end else if (MDUOp == OP_MTLO) begin
                            lo <= dInA;
                        end
                    end
                end
                RUN: begin
                    if (count == '0) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: spec vectors, hand-written pipeline corner
// cases and a randomized run compared cycle by cycle against a transaction-level model.
module tb_mul_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] dInA = 32'd0;
    logic [31:0] dInB = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int nCmp = 0;
    int nBad = 0;
    bit checkEn = 1'b0;

    mul_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .MDUOp (MDUOp),
        .dInA  (dInA),
        .dInB  (dInB),
        .flush (flush),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference arithmetic done in 64-bit integers; the overflow case falls out naturally.
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            4'd1: res = 64'(sa * sb);
            4'd2: res = ua * ub;
            4'd3: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa - q * sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    uq = ua / ub;
                    ur = ua - uq * ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Transaction model: remembers the edge number at which a pending result lands.
    int          cyc = 0;
    bit          mBusy = 1'b0;
    int          mDone = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] pHi = 32'd0;
    logic [31:0] pLo = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1'b0;
            mHi   = 32'd0;
            mLo   = 32'd0;
        end else begin
            cyc = cyc + 1;
            if (flush) begin
                mBusy = 1'b0;
            end else if (mBusy) begin
                if (cyc == mDone) begin
                    mHi   = pHi;
                    mLo   = pLo;
                    mBusy = 1'b0;
                end
            end else if (start) begin
                case (MDUOp)
                    4'd1, 4'd2: begin
                        {pHi, pLo} = refResult(MDUOp, dInA, dInB);
                        mDone = cyc + MUL_LAT;
                        mBusy = 1'b1;
                    end
                    4'd3, 4'd4: begin
                        {pHi, pLo} = refResult(MDUOp, dInA, dInB);
                        mDone = cyc + DIV_LAT;
                        mBusy = 1'b1;
                    end
                    4'd5: mHi = dInA;
                    4'd6: mLo = dInA;
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every cycle, after the inputs have settled, the DUT must agree with the model.
    always @(negedge clk) begin
        #2;
        if (checkEn) begin
            checkOutput("model_busy", {31'd0, busy}, {31'd0, mBusy});
            checkOutput("model_stall", {31'd0, stall},
                        {31'd0, mBusy | (start && MDUOp >= 4'd1 && MDUOp <= 4'd4)});
            checkOutput("model_hi", hi, mHi);
            checkOutput("model_lo", lo, mLo);
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic f);
        @(negedge clk);
        start = 1'b1;
        MDUOp = op;
        dInA  = a;
        dInB  = b;
        flush = f;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            MDUOp = 4'd0;
        end
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            idle(1);
            #2;
            if (!busy) return;
            n++;
        end
        nCmp++;
        nBad++;
        $display("[TB] FAIL wait_idle: busy still 1 after 50 cycles, expected 0");
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        bit rs, rf;

        vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT};
        vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[3] = '{4'd4, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF, DIV_LAT};
        vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, DIV_LAT};
        vecs[5] = '{4'd3, 32'd0,         32'd0,          32'd0,         32'hFFFF_FFFF, DIV_LAT};
        vecs[6] = '{4'd4, 32'd100,       32'd7,          32'd2,         32'd14,        DIV_LAT};
        vecs[7] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, DIV_LAT};
        vecs[8] = '{4'd1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         MUL_LAT};
        vecs[9] = '{4'd1, 32'h7FFF_FFFF, 32'd2,          32'd0,         32'hFFFF_FFFE, MUL_LAT};

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        checkEn = 1'b1;
        idle(3);
        #2;
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_reset_hi", hi, 32'd0);

        $display("[TB] mthi/mtlo and stall");
        applyStimulus(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        #2 checkOutput("mthi_stall", {31'd0, stall}, 32'd0);
        applyStimulus(4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
        #2 checkOutput("mtlo_stall", {31'd0, stall}, 32'd0);
        checkOutput("mthi_hi", hi, 32'h1234_5678);
        checkOutput("mthi_lo_kept", lo, 32'd0);
        applyStimulus(4'd1, 32'd3, 32'd4, 1'b0);
        #2 checkOutput("issue_stall", {31'd0, stall}, 32'd1);
        checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
        checkOutput("issue_busy", {31'd0, busy}, 32'd0);
        waitIdle(n);
        checkOutput("mult_lat", n, MUL_LAT);
        checkOutput("mult_lo", lo, 32'd12);
        checkOutput("mult_hi", hi, 32'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            waitIdle(n);
            checkOutput($sformatf("vec%0d_lat", i), n, vecs[i].lat);
            checkOutput($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
            checkOutput($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        for (int i = 1; i <= DIV_LAT; i++) begin
            if (i == 3) applyStimulus(4'd3, 32'd100, 32'd3, 1'b0);
            else idle(1);
            #2 checkOutput($sformatf("ign_busy_c%0d", i), {31'd0, busy}, 32'd1);
        end
        idle(1);
        #2;
        checkOutput("ign_busy_drop", {31'd0, busy}, 32'd0);
        checkOutput("ign_lo", lo, 32'hFFFF_FFFD);
        checkOutput("ign_hi", hi, 32'hFFFF_FFFF);

        $display("[TB] flush cases");
        applyStimulus(4'd3, 32'd100, 32'd7, 1'b0);
        idle(1);
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b1);
        start = 1'b0;
        idle(1);
        #2;
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_hi", hi, 32'hFFFF_FFFF);
        checkOutput("flush_lo", lo, 32'hFFFF_FFFD);
        applyStimulus(4'd3, 32'd100, 32'd7, 1'b1);
        idle(1);
        #2 checkOutput("flush_start_busy", {31'd0, busy}, 32'd0);
        idle(DIV_LAT);
        #2 checkOutput("flush_start_lo", lo, 32'hFFFF_FFFD);
        applyStimulus(4'd4, 32'd100, 32'd7, 1'b0);
        idle(DIV_LAT - 1);
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b1);
        start = 1'b0;
        idle(1);
        #2;
        checkOutput("flush_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_done_hi", hi, 32'hFFFF_FFFF);
        checkOutput("flush_done_lo", lo, 32'hFFFF_FFFD);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(4'd3, 32'd1000, 32'd3, 1'b0);
        idle(2);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_hi", hi, 32'd0);
        checkOutput("async_lo", lo, 32'd0);
        #2 rst_n = 1'b1;
        idle(DIV_LAT + 3);
        #2;
        checkOutput("async_after_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_after_hi", hi, 32'd0);
        checkOutput("async_after_lo", lo, 32'd0);

        $display("[TB] randomized run");
        for (int i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 99) < 40);
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 19) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            rf = ($urandom_range(0, 99) < 4);
            applyStimulus(rop, ra, rb, rf);
            start = rs;
        end
        idle(DIV_LAT + 5);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
